// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and presents {pc, pc+4, inst, valid} to the IF/ID register. It parks one response
// during a stall and discards in-flight responses that a redirect has made stale.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  // The skid buffer is occupied exactly when the FSM sits in StHold.
  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StDrop,
    StHold
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic [31:0] addr_plus_4;
  assign addr_plus_4 = addr_q + 32'd4;

  // Next-state, PC, request address, skid buffer and presented-output selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    out_pc_d    = out_pc_q;
    out_pc4_d   = out_pc4_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    unique case (state_q)
      StBoot: begin
        // Any rvalid seen here is left over from before reset and is ignored.
        state_d = StReq;
        if (redirect) begin
          pc_d   = redirect_pc;
          addr_d = redirect_pc;
        end else begin
          addr_d = pc_q;
        end
      end

      StReq: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_inst_d  = NOP_INST;
          out_valid_d = 1'b0;
          if (imem_rvalid) begin
            // Response retired this cycle, so the new target can be requested at once.
            state_d = StReq;
            addr_d  = redirect_pc;
          end else begin
            // Old request is still in flight; keep it stable until it drains.
            state_d = StDrop;
          end
        end else if (imem_rvalid) begin
          pc_d   = addr_plus_4;
          addr_d = addr_plus_4;
          if (stall) begin
            skid_pc_d   = addr_q;
            skid_inst_d = imem_rdata;
            state_d     = StHold;
          end else begin
            out_pc_d    = addr_q;
            out_pc4_d   = addr_plus_4;
            out_inst_d  = imem_rdata;
            out_valid_d = 1'b1;
          end
        end else if (!stall) begin
          // Nothing arrived: present a bubble, keep the last PC visible.
          out_inst_d  = NOP_INST;
          out_valid_d = 1'b0;
        end
      end

      StDrop: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_inst_d  = NOP_INST;
          out_valid_d = 1'b0;
          // If the stale response lands in the same cycle, the drain is over too.
          if (imem_rvalid) begin
            state_d = StReq;
            addr_d  = redirect_pc;
          end
        end else if (imem_rvalid) begin
          state_d = StReq;
          addr_d  = pc_q;
        end
      end

      StHold: begin
        if (redirect) begin
          // Leaving StHold flushes the parked response.
          pc_d        = redirect_pc;
          addr_d      = redirect_pc;
          out_inst_d  = NOP_INST;
          out_valid_d = 1'b0;
          state_d     = StReq;
        end else if (!stall) begin
          out_pc_d    = skid_pc_q;
          out_pc4_d   = skid_pc_q + 32'd4;
          out_inst_d  = skid_inst_q;
          out_valid_d = 1'b1;
          addr_d      = pc_q;
          state_d     = StReq;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase

    req_d = (state_d == StReq) || (state_d == StDrop);
  end

  // State and datapath registers; reset drops any outstanding request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      out_pc_q    <= 32'd0;
      out_pc4_q   <= 32'd0;
      out_inst_q  <= NOP_INST;
      out_valid_q <= 1'b0;
      skid_pc_q   <= 32'd0;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      out_pc_q    <= out_pc_d;
      out_pc4_q   <= out_pc4_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign pc_out        = out_pc_q;
  assign pc_plus_4_out = out_pc4_q;
  assign inst_out      = out_inst_q;
  assign inst_valid    = out_valid_q;

endmodule
